// File: rtl/tag_lookup_pkg.sv
// Shared constants and types for the associative tag lookup table.
// The derived widths below describe the default geometry (32-bit access
// address, 4 words/block, 64 blocks, 4 ways). A cache controller built
// around the table can reuse them directly.
package tag_lookup_pkg;

  localparam int BW_ACCESS_ADDR_DFLT    = 32;
  localparam int N_WORDS_PER_BLOCK_DFLT = 4;
  localparam int N_CAPACITY_BLOCKS_DFLT = 64;
  localparam int ASSOCIATIVITY_DFLT     = 4;

  // offset bits inside a block
  localparam int BW_WORDS_PER_BLOCK = $clog2(N_WORDS_PER_BLOCK_DFLT);
  // way-select bits (one way out of the set of ASSOCIATIVITY)
  localparam int BW_ACCESS_SET      = $clog2(ASSOCIATIVITY_DFLT);
  // number of groups
  localparam int G                  = N_CAPACITY_BLOCKS_DFLT / ASSOCIATIVITY_DFLT;
  localparam int BW_ACCESS_GROUP    = $clog2(G);
  localparam int BW_ACCESS_TAG      = BW_ACCESS_ADDR_DFLT - BW_WORDS_PER_BLOCK - BW_ACCESS_GROUP;
  localparam int BW_CAPACITY_DFLT   = $clog2(N_CAPACITY_BLOCKS_DFLT);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

  function automatic int n_groups(input int cap_blocks, input int assoc);
    return cap_blocks / assoc;
  endfunction

endpackage

// File: rtl/tag_lookup_table_assoc_if.sv
// Lookup request/response bundle of the tag table.
//   req_valid_i / req_ready_o / req_addr_i : lookup request handshake
//   rsp_valid_o, rsp_hit_o, rsp_cache_addr_o : lookup result (one cycle later)
//   rsp_free_o, rsp_free_addr_o            : lowest invalid way in the group
// master = requester (cache controller), slave = tag table.
interface tag_lookup_table_assoc_if
  import tag_lookup_pkg::*;
#(
  parameter int BW_ACCESS_ADDR     = BW_ACCESS_ADDR_DFLT,
  parameter int BW_CAPACITY_BLOCKS = BW_CAPACITY_DFLT
);
  logic                          req_valid_i;
  logic                          req_ready_o;
  logic [BW_ACCESS_ADDR-1:0]     req_addr_i;
  logic                          rsp_valid_o;
  logic                          rsp_hit_o;
  logic [BW_CAPACITY_BLOCKS-1:0] rsp_cache_addr_o;
  logic                          rsp_free_o;
  logic [BW_CAPACITY_BLOCKS-1:0] rsp_free_addr_o;

  modport master (
    output req_valid_i, req_addr_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_cache_addr_o,
           rsp_free_o, rsp_free_addr_o
  );

  modport slave (
    input  req_valid_i, req_addr_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_cache_addr_o,
           rsp_free_o, rsp_free_addr_o
  );
endinterface

// File: rtl/tag_lookup_table_assoc_way_priority_encoder.sv
// Priority encoder over a per-way flag vector.
//   vec_i : one flag per way
//   any_o : at least one flag set
//   hi_o  : index of the highest set flag (0 when none)
//   lo_o  : index of the lowest set flag (0 when none)
// Used for hit selection (highest matching way) and free-way selection
// (lowest invalid way).
module way_priority_encoder
  import tag_lookup_pkg::*;
#(
  parameter  int ASSOCIATIVITY = ASSOCIATIVITY_DFLT,
  localparam int WAY_W         = $clog2(ASSOCIATIVITY)
) (
  input  logic [ASSOCIATIVITY-1:0] vec_i,
  output logic                     any_o,
  output logic [WAY_W-1:0]         hi_o,
  output logic [WAY_W-1:0]         lo_o
);

  always_comb begin
    any_o = |vec_i;
    hi_o  = '0;
    lo_o  = '0;
    // ascending scan: the last set flag seen is the highest
    for (int i = 0; i < ASSOCIATIVITY; i++)
      if (vec_i[i]) hi_o = WAY_W'(i);
    // descending scan: the last set flag seen is the lowest
    for (int i = ASSOCIATIVITY - 1; i >= 0; i--)
      if (vec_i[i]) lo_o = WAY_W'(i);
  end

endmodule

// File: rtl/tag_lookup_table_assoc.sv
// Set-associative tag lookup table.
//   clock_i, reset_i            : clock, synchronous active-high reset
//   lk (slave)                  : lookup request/response bundle
//   wren_i, rmen_i              : write / remove entry at cache_addr_i
//   access_addr_write_i         : address whose tag gets written
//   cache_addr_i                : entry address {way, group}
//   access_addr_search_o        : reverse translation of cache_addr_i
//   flush_i, flush_busy_o,
//   flush_done_o                : invalidate-all, one group per cycle
// Address split: {tag, group, offset}. Cache address: {way, group}.
// Lookups read the table as it stands before the same-edge update.
module tag_lookup_table_assoc
  import tag_lookup_pkg::*;
#(
  parameter  int BW_ACCESS_ADDR     = BW_ACCESS_ADDR_DFLT,
  parameter  int N_WORDS_PER_BLOCK  = N_WORDS_PER_BLOCK_DFLT,
  parameter  int N_CAPACITY_BLOCKS  = N_CAPACITY_BLOCKS_DFLT,
  parameter  int ASSOCIATIVITY      = ASSOCIATIVITY_DFLT,
  localparam int BW_CAPACITY_BLOCKS = $clog2(N_CAPACITY_BLOCKS)
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  tag_lookup_table_assoc_if.slave       lk,
  input  logic                          wren_i,
  input  logic                          rmen_i,
  input  logic [BW_ACCESS_ADDR-1:0]     access_addr_write_i,
  input  logic [BW_CAPACITY_BLOCKS-1:0] cache_addr_i,
  output logic [BW_ACCESS_ADDR-1:0]     access_addr_search_o,
  input  logic                          flush_i,
  output logic                          flush_busy_o,
  output logic                          flush_done_o
);

  localparam int OFF_W = $clog2(N_WORDS_PER_BLOCK);
  localparam int N_GRP = n_groups(N_CAPACITY_BLOCKS, ASSOCIATIVITY);
  localparam int GRP_W = $clog2(N_GRP);
  localparam int WAY_W = $clog2(ASSOCIATIVITY);
  localparam int TAG_W = BW_ACCESS_ADDR - OFF_W - GRP_W;

  // table state
  logic [N_CAPACITY_BLOCKS-1:0]            valid_q, valid_d;
  logic [N_CAPACITY_BLOCKS-1:0][TAG_W-1:0] tag_q, tag_d;

  // flush FSM
  flush_state_e     state_q, state_d;
  logic [GRP_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // registered lookup result
  logic                          rsp_valid_q, rsp_valid_d;
  logic                          rsp_hit_q, rsp_hit_d;
  logic [BW_CAPACITY_BLOCKS-1:0] rsp_caddr_q, rsp_caddr_d;
  logic                          rsp_free_q, rsp_free_d;
  logic [BW_CAPACITY_BLOCKS-1:0] rsp_faddr_q, rsp_faddr_d;

  // ---------------- lookup path ----------------
  // Shifts instead of part-selects keep a zero-width offset legal.
  logic [GRP_W-1:0]         lk_grp;
  logic [TAG_W-1:0]         lk_tag;
  logic [ASSOCIATIVITY-1:0] hit_vec, free_vec;
  logic                     hit_any, free_any;
  logic [WAY_W-1:0]         hit_way, free_way;
  logic [WAY_W-1:0]         hit_lo_unused, free_hi_unused;
  logic                     req_ready, accept;

  assign lk_grp = GRP_W'(lk.req_addr_i >> OFF_W);
  assign lk_tag = TAG_W'(lk.req_addr_i >> (OFF_W + GRP_W));

  for (genvar w = 0; w < ASSOCIATIVITY; w++) begin : g_way
    localparam logic [WAY_W-1:0] WI = WAY_W'(w);
    assign hit_vec[w]  = valid_q[{WI, lk_grp}] && (tag_q[{WI, lk_grp}] == lk_tag);
    assign free_vec[w] = !valid_q[{WI, lk_grp}];
  end

  way_priority_encoder #(.ASSOCIATIVITY(ASSOCIATIVITY)) u_hit_enc (
    .vec_i (hit_vec),
    .any_o (hit_any),
    .hi_o  (hit_way),
    .lo_o  (hit_lo_unused)
  );

  way_priority_encoder #(.ASSOCIATIVITY(ASSOCIATIVITY)) u_free_enc (
    .vec_i (free_vec),
    .any_o (free_any),
    .hi_o  (free_hi_unused),
    .lo_o  (free_way)
  );

  // Ready drops combinationally with reset so nothing is accepted
  // while the table is being cleared.
  assign req_ready = (state_q == ST_IDLE) && !reset_i;
  assign accept    = lk.req_valid_i && req_ready;

  always_comb begin
    rsp_valid_d = accept;
    rsp_hit_d   = accept && hit_any;
    rsp_caddr_d = (accept && hit_any)  ? {hit_way, lk_grp}  : '0;
    rsp_free_d  = accept && free_any;
    rsp_faddr_d = (accept && free_any) ? {free_way, lk_grp} : '0;
  end

  // ---------------- table update ----------------
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (state_q == ST_IDLE) begin
      if (wren_i) begin
        tag_d[cache_addr_i]   = TAG_W'(access_addr_write_i >> (OFF_W + GRP_W));
        valid_d[cache_addr_i] = 1'b1;
      end
      // remove after write: same-entry write+remove leaves it invalid
      if (rmen_i) valid_d[cache_addr_i] = 1'b0;
    end else begin
      for (int w = 0; w < ASSOCIATIVITY; w++)
        valid_d[{WAY_W'(w), cnt_q}] = 1'b0;
    end
  end

  // ---------------- flush FSM next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == GRP_W'(N_GRP - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      valid_q     <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_caddr_q <= '0;
      rsp_free_q  <= 1'b0;
      rsp_faddr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_caddr_q <= rsp_caddr_d;
      rsp_free_q  <= rsp_free_d;
      rsp_faddr_q <= rsp_faddr_d;
    end
  end

  // ---------------- outputs ----------------
  assign lk.req_ready_o      = req_ready;
  assign lk.rsp_valid_o      = rsp_valid_q;
  assign lk.rsp_hit_o        = rsp_hit_q;
  assign lk.rsp_cache_addr_o = rsp_caddr_q;
  assign lk.rsp_free_o       = rsp_free_q;
  assign lk.rsp_free_addr_o  = rsp_faddr_q;
  assign flush_busy_o        = (state_q == ST_FLUSH);
  assign flush_done_o        = done_q;

  // Reverse translation ignores the valid bit on purpose: the controller
  // uses it to rebuild the address of a victim it is about to evict.
  assign access_addr_search_o =
      (BW_ACCESS_ADDR'(tag_q[cache_addr_i]) << (OFF_W + GRP_W)) |
      (BW_ACCESS_ADDR'(cache_addr_i[GRP_W-1:0]) << OFF_W);

endmodule

// File: tb/tb_tag_lookup_table_assoc.sv
module tb_tag_lookup_table_assoc;

  localparam int NG   = 16;  // groups
  localparam int NWAY = 4;
  localparam int NENT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        wren, rmen, flush;
  logic [31:0] waddr;
  logic [5:0]  caddr;
  logic [31:0] search;
  logic        busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  tag_lookup_table_assoc_if #(.BW_ACCESS_ADDR(32), .BW_CAPACITY_BLOCKS(6)) bus ();

  tag_lookup_table_assoc dut (
    .clock_i              (clk),
    .reset_i              (rst),
    .lk                   (bus),
    .wren_i               (wren),
    .rmen_i               (rmen),
    .access_addr_write_i  (waddr),
    .cache_addr_i         (caddr),
    .access_addr_search_o (search),
    .flush_i              (flush),
    .flush_busy_o         (busy),
    .flush_done_o         (done)
  );

  always #5 clk = ~clk;

  // reference model: per entry valid flag and stored tag
  logic        m_valid [NENT];
  logic [25:0] m_tag   [NENT];

  // sampled after each edge
  logic [14:0] s_rsp;
  logic        s_busy, s_done, s_ready;

  function automatic logic [31:0] mk_addr(input int tag, input int grp, input int off);
    return 32'(tag * 64 + grp * 4 + off);
  endfunction

  // expected {valid, hit, cache_addr, free, free_addr} of a lookup
  function automatic logic [14:0] exp_lookup(input logic [31:0] a);
    int grp, hw, fw;
    logic [25:0] t;
    logic hit, fr;
    grp = int'((a / 4) % NG);
    t   = 26'(a / 64);
    hit = 1'b0; hw = 0;
    for (int w = 0; w < NWAY; w++)
      if (m_valid[w * NG + grp] && m_tag[w * NG + grp] == t) begin hit = 1'b1; hw = w; end
    fr = 1'b0; fw = 0;
    for (int w = NWAY - 1; w >= 0; w--)
      if (!m_valid[w * NG + grp]) begin fr = 1'b1; fw = w; end
    return {1'b1, hit, hit ? 6'(hw * NG + grp) : 6'd0, fr, fr ? 6'(fw * NG + grp) : 6'd0};
  endfunction

  task automatic m_clear();
    for (int e = 0; e < NENT; e++) begin m_valid[e] = 1'b0; m_tag[e] = '0; end
  endtask

  task automatic m_apply(input logic we, input logic rm, input logic [31:0] wa, input logic [5:0] ca);
    if (we) begin m_tag[ca] = 26'(wa / 64); m_valid[ca] = 1'b1; end
    if (rm) m_valid[ca] = 1'b0;
  endtask

  // drive one cycle, sample after the edge, return to idle inputs
  task automatic cyc(input logic rv, input logic [31:0] ra, input logic we, input logic rm,
                     input logic [31:0] wa, input logic [5:0] ca, input logic fl);
    bus.req_valid_i = rv; bus.req_addr_i = ra;
    wren = we; rmen = rm; waddr = wa; caddr = ca; flush = fl;
    @(posedge clk); #1;
    s_rsp   = {bus.rsp_valid_o, bus.rsp_hit_o, bus.rsp_cache_addr_o,
               bus.rsp_free_o, bus.rsp_free_addr_o};
    s_busy  = busy;
    s_done  = done;
    s_ready = bus.req_ready_o;
    bus.req_valid_i = 1'b0; wren = 1'b0; rmen = 1'b0; flush = 1'b0;
  endtask

  // idle-state cycle with model prediction (lookup sees pre-write state)
  task automatic step(input logic rv, input logic [31:0] ra, input logic we, input logic rm,
                      input logic [31:0] wa, input logic [5:0] ca, output logic [14:0] exp);
    exp = rv ? exp_lookup(ra) : 15'd0;
    m_apply(we, rm, wa, ca);
    cyc(rv, ra, we, rm, wa, ca, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_clear();
    cyc(1'b1, 32'h1230, 1'b1, 1'b0, 32'h1230, 6'd1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd0, 1'b0);
    n_checks++;
    if (s_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", s_ready); else n_pass++;
    n_checks++;
    if ({s_rsp, s_busy, s_done} !== 17'd0)
      $display("FAIL reset_outputs: got %h want 0", {s_rsp, s_busy, s_done}); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready_o !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", bus.req_ready_o);
    else n_pass++;
    caddr = 6'd1; #1;
    n_checks++;
    if (search !== 32'h4) $display("FAIL search_after_reset: got %h want 00000004", search);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [14:0] exp;
    logic [5:0]  ca;
    int          g;
    g  = (32'h1230 / 4) % NG;
    ca = 6'(2 * NG + g);
    step(1'b1, 32'h1230, 1'b0, 1'b0, 32'h0, 6'd0, exp);
    n_checks++;
    if (s_rsp !== exp) $display("FAIL first_lookup: got %h want %h", s_rsp, exp); else n_pass++;
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h1230, ca, exp);
    step(1'b1, 32'h1230, 1'b0, 1'b0, 32'h0, 6'd0, exp);
    n_checks++;
    if (s_rsp !== exp) $display("FAIL hit_after_write: got %h want %h", s_rsp, exp); else n_pass++;
    caddr = ca; #1;
    n_checks++;
    if (search !== 32'h0000_1230) $display("FAIL search_reverse: got %h want 00001230", search);
    else n_pass++;
  endtask

  task automatic test_read_before_write();
    logic [14:0] exp;
    logic [31:0] a;
    a = 32'h0000_5670;
    step(1'b1, a, 1'b1, 1'b0, a, 6'((a / 4) % NG), exp);
    n_checks++;
    if (s_rsp !== exp || s_rsp[13] !== 1'b0)
      $display("FAIL rbw_same_edge: got %h want %h", s_rsp, exp); else n_pass++;
    step(1'b1, a, 1'b0, 1'b0, 32'h0, 6'd0, exp);
    n_checks++;
    if (s_rsp !== exp || s_rsp[13] !== 1'b1)
      $display("FAIL rbw_next_lookup: got %h want %h", s_rsp, exp); else n_pass++;
  endtask

  task automatic test_full_group();
    logic [14:0] exp;
    for (int w = 0; w < NWAY; w++)
      step(1'b0, 32'h0, 1'b1, 1'b0, mk_addr(32'h100 + w, 5, 0), 6'(w * NG + 5), exp);
    step(1'b1, mk_addr(32'h200, 5, 1), 1'b0, 1'b0, 32'h0, 6'd0, exp);
    n_checks++;
    if (s_rsp !== exp) $display("FAIL full_group_miss: got %h want %h", s_rsp, exp); else n_pass++;
    step(1'b0, 32'h0, 1'b1, 1'b1, mk_addr(32'h300, 5, 0), 6'(NG + 5), exp);
    step(1'b1, mk_addr(32'h300, 5, 2), 1'b0, 1'b0, 32'h0, 6'd0, exp);
    n_checks++;
    if (s_rsp !== exp) $display("FAIL wr_rm_same_entry: got %h want %h", s_rsp, exp); else n_pass++;
    caddr = 6'(NG + 5); #1;
    n_checks++;
    if (search !== mk_addr(32'h300, 5, 0))
      $display("FAIL search_ignores_valid: got %h want %h", search, mk_addr(32'h300, 5, 0));
    else n_pass++;
  endtask

  task automatic test_multi_hit();
    logic [14:0] exp;
    step(1'b0, 32'h0, 1'b1, 1'b0, mk_addr(32'h55, 7, 0), 6'(0 * NG + 7), exp);
    step(1'b0, 32'h0, 1'b1, 1'b0, mk_addr(32'h56, 7, 0), 6'(1 * NG + 7), exp);
    step(1'b0, 32'h0, 1'b1, 1'b0, mk_addr(32'h55, 7, 0), 6'(3 * NG + 7), exp);
    step(1'b1, mk_addr(32'h55, 7, 3), 1'b0, 1'b0, 32'h0, 6'd0, exp);
    n_checks++;
    if (s_rsp !== exp) $display("FAIL multi_hit_highest: got %h want %h", s_rsp, exp); else n_pass++;
  endtask

  task automatic test_random();
    logic [14:0] exp;
    logic        rv, we, rm;
    logic [31:0] ra, wa;
    logic [5:0]  ca;
    for (int i = 0; i < 400; i++) begin
      rv = 1'($urandom_range(0, 3) != 0);
      ra = mk_addr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      we = 1'($urandom_range(0, 2) == 0);
      rm = 1'($urandom_range(0, 5) == 0);
      wa = mk_addr($urandom_range(0, 3), 0, $urandom_range(0, 3));
      ca = 6'($urandom_range(0, 3) * NG + $urandom_range(0, 3));
      step(rv, ra, we, rm, wa, ca, exp);
      n_checks++;
      if (s_rsp !== exp) $display("FAIL random_lookup[%0d]: got %h want %h", i, s_rsp, exp);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    logic [14:0] exp;
    logic [31:0] hit_a;
    logic [31:0] q[$];
    int busy_cnt, done_cnt, bad_ready, bad_acc;
    hit_a = mk_addr(32'h77, 9, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0, hit_a, 6'd9, exp);
    for (int e = 0; e < NENT; e++)
      if (m_valid[e]) q.push_back(mk_addr(int'(m_tag[e]), e % NG, 0));
    // lookup accepted together with flush_i uses pre-flush contents
    exp = exp_lookup(hit_a);
    cyc(1'b1, hit_a, 1'b0, 1'b0, 32'h0, 6'd0, 1'b1);
    n_checks++;
    if (s_rsp !== exp) $display("FAIL lookup_at_flush_start: got %h want %h", s_rsp, exp);
    else n_pass++;
    busy_cnt = int'(s_busy); done_cnt = int'(s_done); bad_ready = 0; bad_acc = 0;
    for (int i = 0; i < 40 && s_busy; i++) begin
      cyc(1'b1, hit_a, 1'b1, 1'b0, mk_addr($urandom_range(0, 3), 9, 0),
          6'($urandom_range(0, 63)), 1'b1);
      if (s_rsp[14] !== 1'b0) bad_acc++;
      if (s_ready !== !s_busy) bad_ready++;
      busy_cnt += int'(s_busy);
      done_cnt += int'(s_done);
    end
    n_checks++;
    if (busy_cnt != NG) $display("FAIL flush_busy_cycles: got %0d want %0d", busy_cnt, NG);
    else n_pass++;
    n_checks++;
    if (done_cnt != 1) $display("FAIL flush_done_pulses: got %0d want 1", done_cnt); else n_pass++;
    n_checks++;
    if (bad_acc != 0) $display("FAIL accept_during_flush: got %0d want 0", bad_acc); else n_pass++;
    n_checks++;
    if (bad_ready != 0) $display("FAIL ready_during_flush: got %0d want 0", bad_ready); else n_pass++;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd0, 1'b0);
    n_checks++;
    if ({s_busy, s_done} !== 2'b00) $display("FAIL after_flush_idle: got %b want 00", {s_busy, s_done});
    else n_pass++;
    for (int e = 0; e < NENT; e++) m_valid[e] = 1'b0;
    foreach (q[k]) begin
      step(1'b1, q[k], 1'b0, 1'b0, 32'h0, 6'd0, exp);
      n_checks++;
      if (s_rsp !== exp || s_rsp[13] !== 1'b0)
        $display("FAIL post_flush_lookup[%0d]: got %h want %h", k, s_rsp, exp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [14:0] exp;
    logic        busy_seen, done_seen;
    for (int w = 0; w < NWAY; w++)
      step(1'b0, 32'h0, 1'b1, 1'b0, mk_addr(32'h40 + w, 2, 0), 6'(w * NG + 2), exp);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, mk_addr(32'h40, 2, 0), 1'b0, 1'b0, 32'h0, 6'd0, 1'b0);
    n_checks++;
    if (s_rsp !== 15'd0) $display("FAIL no_rsp_in_reset: got %h want 0", s_rsp); else n_pass++;
    rst = 1'b0;
    m_clear();
    busy_seen = 1'b0; done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd0, 1'b0);
      busy_seen |= s_busy;
      done_seen |= s_done;
    end
    n_checks++;
    if ({busy_seen, done_seen} !== 2'b00)
      $display("FAIL aborted_flush_status: got %b want 00", {busy_seen, done_seen}); else n_pass++;
    for (int w = 0; w < NWAY; w++) begin
      step(1'b1, mk_addr(32'h40 + w, 2, 1), 1'b0, 1'b0, 32'h0, 6'd0, exp);
      n_checks++;
      if (s_rsp !== exp || s_rsp[13] !== 1'b0)
        $display("FAIL post_reset_lookup[%0d]: got %h want %h", w, s_rsp, exp); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; wren = 1'b0; rmen = 1'b0; flush = 1'b0;
    waddr = '0; caddr = '0;
    bus.req_valid_i = 1'b0; bus.req_addr_i = '0;
    m_clear();
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_read_before_write();
    test_full_group();
    test_multi_hit();
    test_random();
    test_flush();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
